// File: rtl/rot_share_pkg.sv
// Shared types and helpers for the rotator-sharing arbiter.
package rot_share_pkg;

  localparam int NREQ_MAX  = 16;
  localparam int WIDTH_MAX = 64;
  localparam int AMT_MAX   = $clog2(WIDTH_MAX);

  // One requester's operands, sized for the widest supported datapath.
  typedef struct packed {
    logic [WIDTH_MAX-1:0] x;
    logic                 right;
    logic [AMT_MAX-1:0]   amt;
  } rot_req_t;

  // Index k positions past 'last', wrapping over n requesters.
  function automatic int rr_next(input int last, input int k, input int n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/rotator.sv
// Combinational rotate left/right of a WIDTH-bit word by amt positions.
module rotator #(
  parameter int WIDTH = 32,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  input  logic             right,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] y
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] shift_all;
  logic [AW:0]        shamt;
  logic               unused_hi;

  // A left rotate by k equals a right rotate by WIDTH-k over the doubled word.
  assign dbl       = {x, x};
  assign shamt     = right ? {1'b0, amt} : ((AW + 1)'(WIDTH) - {1'b0, amt});
  assign shift_all = dbl >> shamt;
  assign y         = shift_all[WIDTH-1:0];
  assign unused_hi = ^shift_all[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/rot_share_arb.sv
// Round-robin arbiter sharing one rotator between NREQ valid/ready requesters,
// with optional grant lock and a single registered, backpressured response stage.
module rot_share_arb
  import rot_share_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(WIDTH),
  localparam int IW = $clog2(NREQ)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [NREQ-1:0]   ReqValid,
  output logic [NREQ-1:0]   ReqReady,
  input  logic [NREQ*WIDTH-1:0] ReqX,
  input  logic [NREQ-1:0]   ReqRight,
  input  logic [NREQ*AW-1:0] ReqAmt,
  input  logic [NREQ-1:0]   ReqLock,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [WIDTH-1:0]  RspY,
  output logic [IW-1:0]     RspId
);

  rot_req_t         req_arr [NREQ];
  rot_req_t         sel_req;
  logic             unused_sel;
  logic [WIDTH-1:0] rot_y;

  logic             open;
  logic             xfer;
  logic             gnt_valid;
  logic [IW-1:0]    gnt_id;
  logic [IW-1:0]    cand;

  logic             rsp_valid_reg, rsp_valid_next;
  logic [WIDTH-1:0] rsp_y_reg, rsp_y_next;
  logic [IW-1:0]    rsp_id_reg, rsp_id_next;
  logic [IW-1:0]    last_reg, last_next;
  logic             lock_own_reg, lock_own_next;
  logic [IW-1:0]    lock_id_reg, lock_id_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_arr[gi] = {WIDTH_MAX'(ReqX[gi*WIDTH +: WIDTH]), ReqRight[gi],
                            AMT_MAX'(ReqAmt[gi*AW +: AW])};
      assign ReqReady[gi] = open && gnt_valid && (gnt_id == IW'(gi));
    end
  endgenerate

  assign open = !rsp_valid_reg || RspReady;
  assign xfer = open && gnt_valid;

  // Lock owner wins outright; otherwise scan from last+1, smallest offset kept last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    if (lock_own_reg && ReqValid[lock_id_reg]) begin
      gnt_valid = 1'b1;
      gnt_id    = lock_id_reg;
    end else begin
      for (int k = NREQ; k >= 1; k--) begin
        cand = IW'(rr_next(int'(last_reg), k, NREQ));
        if (ReqValid[cand]) begin
          gnt_valid = 1'b1;
          gnt_id    = cand;
        end
      end
    end
  end

  assign sel_req    = req_arr[gnt_id];
  assign unused_sel = ^sel_req;

  rotator #(.WIDTH(WIDTH)) u_rotator (
    .x     (sel_req.x[WIDTH-1:0]),
    .right (sel_req.right),
    .amt   (sel_req.amt[AW-1:0]),
    .y     (rot_y)
  );

  always_comb begin
    rsp_valid_next = rsp_valid_reg;
    rsp_y_next     = rsp_y_reg;
    rsp_id_next    = rsp_id_reg;
    last_next      = last_reg;
    lock_own_next  = lock_own_reg;
    lock_id_next   = lock_id_reg;
    if (lock_own_reg && !ReqValid[lock_id_reg]) begin
      lock_own_next = 1'b0;
    end
    if (xfer) begin
      rsp_valid_next = 1'b1;
      rsp_y_next     = rot_y;
      rsp_id_next    = gnt_id;
      last_next      = gnt_id;
      lock_own_next  = ReqLock[gnt_id];
      if (ReqLock[gnt_id]) begin
        lock_id_next = gnt_id;
      end
    end else if (RspReady) begin
      rsp_valid_next = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid_reg <= 1'b0;
      rsp_y_reg     <= '0;
      rsp_id_reg    <= '0;
      last_reg      <= IW'(NREQ - 1);
      lock_own_reg  <= 1'b0;
      lock_id_reg   <= '0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      rsp_y_reg     <= rsp_y_next;
      rsp_id_reg    <= rsp_id_next;
      last_reg      <= last_next;
      lock_own_reg  <= lock_own_next;
      lock_id_reg   <= lock_id_next;
    end
  end

  assign RspValid = rsp_valid_reg;
  assign RspY     = rsp_y_reg;
  assign RspId    = rsp_id_reg;

endmodule

// File: tb/tb_rot_share_arb.sv
// Directed plus randomized bench for rot_share_arb (NREQ=2, WIDTH=32) against a
// behavioural model of arbitration, locking and rotation.
module tb_rot_share_arb;

  logic        HCLK;
  logic        HRESETn;
  logic [1:0]  ReqValid;
  logic [1:0]  ReqReady;
  logic [63:0] ReqX;
  logic [1:0]  ReqRight;
  logic [9:0]  ReqAmt;
  logic [1:0]  ReqLock;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspY;
  logic [0:0]  RspId;

  rot_share_arb #(.NREQ(2), .WIDTH(32)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqX     (ReqX),
    .ReqRight (ReqRight),
    .ReqAmt   (ReqAmt),
    .ReqLock  (ReqLock),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspY     (RspY),
    .RspId    (RspId)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Stimulus per requester
  bit          va [2];
  bit          ra [2];
  bit          la [2];
  logic [31:0] xa [2];
  logic [4:0]  ka [2];
  bit          rsp_rdy;

  // Behavioural model state
  int          m_last;
  bit          m_lock_own;
  int          m_lock_id;
  bit          m_valid;
  logic [31:0] m_y;
  int          m_id;
  int          last_xfer;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rot_ref(input logic [31:0] v, input bit r, input int k);
    logic [31:0] o;
    logic [4:0]  src;
    o = '0;
    for (int j = 0; j < 32; j++) begin
      src  = r ? 5'((j + k) % 32) : 5'((j - k + 32) % 32);
      o[j] = v[src];
    end
    return o;
  endfunction

  function automatic int model_grant();
    if (m_lock_own && va[m_lock_id]) return m_lock_id;
    for (int k = 1; k <= 2; k++) begin
      if (va[(m_last + k) % 2]) return (m_last + k) % 2;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last     = 1;
    m_lock_own = 1'b0;
    m_lock_id  = 0;
    m_valid    = 1'b0;
    m_y        = '0;
    m_id       = 0;
  endtask

  task automatic apply();
    ReqValid = {va[1], va[0]};
    ReqX     = {xa[1], xa[0]};
    ReqRight = {ra[1], ra[0]};
    ReqAmt   = {ka[1], ka[0]};
    ReqLock  = {la[1], la[0]};
    RspReady = rsp_rdy;
  endtask

  task automatic new_ops(input int i);
    xa[i] = $urandom;
    ra[i] = 1'($urandom_range(0, 1));
    ka[i] = 5'($urandom_range(0, 31));
  endtask

  // One clock: entered just after a falling edge, leaves at the next falling edge.
  task automatic cycle();
    int         g;
    bit         open;
    logic [1:0] exp_rdy;
    apply();
    #1;
    open    = !m_valid || rsp_rdy;
    g       = model_grant();
    exp_rdy = 2'b00;
    if (open && g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(ReqReady), 64'(exp_rdy));
    if (m_lock_own && !va[m_lock_id]) m_lock_own = 1'b0;
    last_xfer = -1;
    if (open && g >= 0) begin
      m_y       = rot_ref(xa[g], ra[g], int'(ka[g]));
      m_id      = g;
      m_valid   = 1'b1;
      m_last    = g;
      m_lock_own = la[g];
      if (la[g]) m_lock_id = g;
      last_xfer = g;
    end else if (rsp_rdy) begin
      m_valid = 1'b0;
    end
    @(posedge HCLK);
    #1;
    check("rsp_valid", 64'(RspValid), 64'(m_valid));
    if (m_valid) begin
      check("rsp_y", 64'(RspY), 64'(m_y));
      check("rsp_id", 64'(RspId), 64'(m_id));
    end
    if (last_xfer >= 0)
      $display("[TB] t=%0t xfer id=%0d y=%08h", $time, last_xfer, m_y);
    @(negedge HCLK);
  endtask

  initial begin
    logic [31:0] hold_y;
    logic [0:0]  hold_id;
    int          n1;
    int          seq [5];

    // 1. Reset with random inputs
    HRESETn = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      va[i] = 1'($urandom_range(0, 1));
      la[i] = 1'($urandom_range(0, 1));
      new_ops(i);
    end
    rsp_rdy = 1'($urandom_range(0, 1));
    apply();
    repeat (3) @(negedge HCLK);
    check("rst_valid", 64'(RspValid), 64'(0));
    check("rst_y", 64'(RspY), 64'(0));
    check("rst_id", 64'(RspId), 64'(0));
    va[0] = 1'b0; va[1] = 1'b0; la[0] = 1'b0; la[1] = 1'b0;
    rsp_rdy = 1'b1;
    apply();
    HRESETn = 1'b1;
    #1;
    check("idle_ready", 64'(ReqReady), 64'(0));
    @(negedge HCLK);
    va[0] = 1'b1; va[1] = 1'b1;
    cycle();
    check("first_grant", 64'(RspId), 64'(0));

    // 2. Single right rotate
    va[1] = 1'b0;
    xa[0] = 32'h8000_0001; ra[0] = 1'b1; ka[0] = 5'd1;
    cycle();
    check("t2_y", 64'(RspY), 64'h0000_0000_C000_0000);
    check("t2_id", 64'(RspId), 64'(0));

    // 3. Single left rotate, then amount zero
    va[0] = 1'b0; va[1] = 1'b1;
    xa[1] = 32'h1234_5678; ra[1] = 1'b0; ka[1] = 5'd8;
    cycle();
    check("t3_y", 64'(RspY), 64'h0000_0000_3456_7812);
    ka[1] = 5'd0;
    cycle();
    check("t3_y0", 64'(RspY), 64'h0000_0000_1234_5678);

    // 4. Contention
    va[0] = 1'b1; va[1] = 1'b1;
    new_ops(0); new_ops(1);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("contend_id", 64'(RspId), 64'(k % 2));
      check("contend_valid", 64'(RspValid), 64'(1));
      if (last_xfer >= 0) new_ops(last_xfer);
    end

    // 5. Backpressure
    hold_y  = RspY;
    hold_id = RspId;
    rsp_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_ready", 64'(ReqReady), 64'(0));
      check("bp_y_hold", 64'(RspY), 64'(hold_y));
      check("bp_id_hold", 64'(RspId), 64'(hold_id));
    end
    rsp_rdy = 1'b1;
    cycle();
    check("bp_resume_id", 64'(RspId), 64'(0));
    if (last_xfer >= 0) new_ops(last_xfer);

    // 6. Lock held by requester 1 for three transfers, released on the fourth
    seq = '{1, 1, 1, 1, 0};
    n1  = 0;
    for (int k = 0; k < 5; k++) begin
      la[1] = (n1 < 3);
      cycle();
      check("lock_seq", 64'(RspId), 64'(seq[k]));
      if (last_xfer == 1) n1++;
      if (last_xfer >= 0) new_ops(last_xfer);
    end
    la[1] = 1'b0;

    // Randomized traffic: operands held until accepted, random locks and backpressure
    for (int c = 0; c < 80; c++) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        if (last_xfer == i || !va[i]) begin
          va[i] = 1'($urandom_range(0, 1));
          la[i] = ($urandom_range(0, 3) == 0);
          new_ops(i);
        end
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
    end

    // 7. Asynchronous reset mid-operation
    va[0] = 1'b1; va[1] = 1'b0; la[0] = 1'b0; la[1] = 1'b0;
    rsp_rdy = 1'b1;
    cycle();
    rsp_rdy = 1'b0;
    va[0] = 1'b0;
    apply();
    check("pre_rst_valid", 64'(RspValid), 64'(1));
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_rst_valid", 64'(RspValid), 64'(0));
    check("async_rst_y", 64'(RspY), 64'(0));
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    va[0] = 1'b1; va[1] = 1'b1;
    rsp_rdy = 1'b1;
    new_ops(0); new_ops(1);
    cycle();
    check("post_rst_grant", 64'(RspId), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rot_share_arb.md
# rot_share_arb

Round-robin arbiter that shares one `rotator` datapath between `NREQ` requesters, such as multiple AHB managers or execution sources. It uses a valid/ready handshake on every request port and one registered response stage with backpressure. An optional per-requester lock holds the grant across back-to-back transfers. Each response is tagged with the index of the requester that issued it.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, at least 2.
- `WIDTH`, default 32: data width, at least 2. `AW = $clog2(WIDTH)`, `IW = $clog2(NREQ)`.

Ports:
- `HCLK` in, 1: clock. All state updates on the rising edge.
- `HRESETn` in, 1: reset. Asynchronous, active-low.
- `ReqValid` in, NREQ: request present, one bit per requester.
- `ReqReady` out, NREQ: request accepted this cycle. One-hot or zero.
- `ReqX` in, NREQ×WIDTH: operand per requester.
- `ReqRight` in, NREQ: 1 means rotate right, 0 means rotate left.
- `ReqAmt` in, NREQ×AW: rotate amount.
- `ReqLock` in, NREQ: keep the grant after this transfer.
- `RspValid` out, 1: response register full.
- `RspReady` in, 1: consumer accepts the response.
- `RspY` out, WIDTH: rotated result.
- `RspId` out, IW: index of the requester that produced the result.

## Operation
- A transfer occurs on requester i when `ReqValid[i] & ReqReady[i]`. At most one transfer occurs per cycle.
- The response register can take new data (`Open`) when `!RspValid | RspReady`. If it is not `Open`, all `ReqReady` bits are 0.
- Grant selection:
  - If `LockOwn` is valid and `ReqValid[LockId]=1`, grant `LockId`.
  - Otherwise, scan from `Last+1` upward, wrapping modulo NREQ. Grant the first i with `ReqValid[i]=1`.
- `ReqReady[g] = Open & ReqValid[g]`. `ReqReady` depends combinationally on `ReqValid` and `RspReady`.
- The single `rotator` instance receives the granted requester's `ReqX`, `ReqRight` and `ReqAmt`.
- Rotation semantics:
  - Right by k: `Y[j] = X[(j+k) mod WIDTH]`.
  - Left by k: `Y[j] = X[(j-k) mod WIDTH]`.
  - k=0 returns X unchanged.
  - For non-power-of-2 WIDTH, an amount of WIDTH or more is illegal. The output is don't-care; the bench must not drive it.
- On a transfer:
  - `RspY` takes the rotator output. `RspId` takes g. `RspValid` is set to 1. `Last` takes g.
  - If `ReqLock[g]=1`: `LockOwn` is set to 1 and `LockId` takes g.
  - If `ReqLock[g]=0`: `LockOwn` is cleared.
- If `LockOwn=1` and `ReqValid[LockId]=0` in a cycle, `LockOwn` is cleared. Arbitration in that same cycle is normal round-robin.
- If the register is `Open`, there is no transfer and `RspReady=1`, then `RspValid` is cleared.
- Simultaneous consume and accept in one cycle: the register reloads and `RspValid` stays 1. This gives full throughput.
- While `RspValid=1` and `RspReady=0`, `RspY` and `RspId` hold stable.

## Timing
- Latency: a request accepted in cycle t appears on `RspY` with `RspValid` in cycle t+1.
- Throughput: 1 transfer per cycle while `RspReady=1`.
- Reset values:
  - `RspValid=0`, `RspY=0`, `RspId=0`.
  - `Last=NREQ-1`, so requester 0 wins first.
  - `LockOwn=0`, `LockId=0`.
  - `ReqReady=0` for as long as no `ReqValid` is high.
- Reset asserted mid-operation discards the pending response immediately, asynchronously. It does not wait for a clock edge.
- A requester must hold `ReqValid` and its operands stable until `ReqReady`. The block does not check this.
- Fairness: with no locks, any continuously requesting requester is granted within NREQ transfers.

## Structure
- Package `rot_share_pkg` holds `rot_req_t` (struct with x, right, amt) and `NREQ_MAX`.
- The operand mux, the round-robin priority logic and the response register are local to `rot_share_arb`.
- Sub-module: the existing `rotator`, instantiated once with `WIDTH` passed through.
- The round-robin scan can be split into an `rr_pick` sub-module. This is optional.

## Test plan
Defaults for all scenarios: NREQ=2, WIDTH=32.
1. **Reset.** Drive `HRESETn=0` with random inputs, then release. Required: `RspValid=0`, `RspY=0`, `RspId=0`, `ReqReady=00`. The first simultaneous request is granted to requester 0.
2. **Single right rotate.** Requester 0: X=0x8000_0001, Right=1, Amt=1. Required next cycle: `RspY=0xC000_0000`, `RspId=0`.
3. **Single left rotate.** Requester 1: X=0x1234_5678, Right=0, Amt=8. Required: `RspY=0x3456_7812`. With Amt=0 instead: `RspY=0x1234_5678`.
4. **Contention.** Both requesters valid for 6 cycles, `RspReady=1`. Required: `RspId` sequence 0,1,0,1,0,1, and `RspValid` high every cycle.
5. **Backpressure.** Hold `RspReady=0` for 3 cycles while both requesters are valid. Required: `ReqReady=00`, `RspY` and `RspId` stable. When `RspReady` returns to 1, the next grant follows round-robin order.
6. **Lock.** Requester 1 sets `ReqLock=1` for 3 transfers while requester 0 is also valid. Required: `RspId` = 1,1,1,1. The 4th transfer is requester 1's lock-release transfer. The next grant goes to 0.
7. **Reset mid-operation.** Drop `HRESETn` while `RspValid=1`. Required: `RspValid=0` asynchronously.
